// File: rtl/argmax_pkg.sv
// argmax_pkg: shared types and elaboration-time helpers for the streaming argmax unit.
package argmax_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Number of scan beats needed to cover n items at lanes items per beat.
    function automatic int beat_count(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    // Most negative two's-complement value representable in r bits.
    function automatic int min_act(input int r);
        return -(1 << (r - 1));
    endfunction

endpackage

// File: rtl/argmax_lane_cmp.sv
// argmax_lane_cmp: one element of the running (max, second, idx) update.
// Lanes are chained; a disabled lane passes its inputs straight through.
module argmax_lane_cmp #(
    parameter int RESOLUTION = 8,
    parameter int INDEX_W    = 4
) (
    input  logic                         en,
    input  logic signed [RESOLUTION-1:0] x,
    input  logic        [INDEX_W-1:0]    i,
    input  logic signed [RESOLUTION-1:0] max_in,
    input  logic signed [RESOLUTION-1:0] sec_in,
    input  logic        [INDEX_W-1:0]    idx_in,
    output logic signed [RESOLUTION-1:0] max_out,
    output logic signed [RESOLUTION-1:0] sec_out,
    output logic        [INDEX_W-1:0]    idx_out
);

    // Greater-or-equal on the max makes ties resolve to the later index.
    always_comb begin
        max_out = max_in;
        sec_out = sec_in;
        idx_out = idx_in;
        if (en) begin
            if (x >= max_in) begin
                sec_out = max_in;
                max_out = x;
                idx_out = i;
            end else if (x >= sec_in) begin
                sec_out = x;
            end
        end
    end

endmodule

// File: rtl/argmax_stream_unit.sv
// argmax_stream_unit: accepts a packed activation vector, scans it LANES
// elements per cycle and returns winner index, max, runner-up and margin.
// Optional macro ARGMAX_CONFIDENCE_EN adds CONF_THRESHOLD and low_confidence.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready high
// SCAN  | one beat of LANES elements folded into the running result per cycle
// DONE  | result registered, out_valid high until out_ready
module argmax_stream_unit
    import argmax_pkg::*;
#(
    parameter int NEURON_NUMBER = 10,
    parameter int RESOLUTION    = 8,
    parameter int LANES         = 1,
`ifdef ARGMAX_CONFIDENCE_EN
    parameter int CONF_THRESHOLD = 16,
`endif
    localparam int INDEX_W = index_width(NEURON_NUMBER)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [RESOLUTION*NEURON_NUMBER-1:0] output_activations,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [INDEX_W-1:0]                  predicted_digit,
    output logic [RESOLUTION-1:0]               max_activation,
    output logic [RESOLUTION-1:0]               runner_up,
`ifdef ARGMAX_CONFIDENCE_EN
    output logic                                low_confidence,
`endif
    output logic [RESOLUTION:0]                 margin
);

    localparam int NUM_BEATS = beat_count(NEURON_NUMBER, LANES);
    localparam int BEAT_W    = index_width(NUM_BEATS);
    localparam logic signed [RESOLUTION-1:0] MIN_ACT = RESOLUTION'(min_act(RESOLUTION));

    state_t                       state;
    logic        [BEAT_W-1:0]     beat;
    logic signed [RESOLUTION-1:0] vec_q [NEURON_NUMBER];
    logic signed [RESOLUTION-1:0] run_max;
    logic signed [RESOLUTION-1:0] run_sec;
    logic        [INDEX_W-1:0]    run_idx;

    logic                         lane_en [LANES];
    logic signed [RESOLUTION-1:0] lane_x  [LANES];
    logic        [INDEX_W-1:0]    lane_i  [LANES];

    logic signed [RESOLUTION-1:0] chain_max [LANES+1];
    logic signed [RESOLUTION-1:0] chain_sec [LANES+1];
    logic        [INDEX_W-1:0]    chain_idx [LANES+1];

    logic [RESOLUTION:0] margin_next;
    logic                accept;
    logic                last_beat;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat == BEAT_W'(NUM_BEATS - 1));

    // Capture the vector on acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NEURON_NUMBER; k++) begin
                vec_q[k] <= output_activations[k*RESOLUTION +: RESOLUTION];
            end
        end
    end

    // Route the elements of the current beat to the lanes; lanes past the end of the vector idle.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_en[l] = 1'b0;
            lane_x[l]  = '0;
            lane_i[l]  = '0;
            for (int k = 0; k < NEURON_NUMBER; k++) begin
                if (int'(beat) * LANES + l == k) begin
                    lane_en[l] = 1'b1;
                    lane_x[l]  = vec_q[k];
                    lane_i[l]  = INDEX_W'(k);
                end
            end
        end
    end

    assign chain_max[0] = run_max;
    assign chain_sec[0] = run_sec;
    assign chain_idx[0] = run_idx;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        argmax_lane_cmp #(
            .RESOLUTION (RESOLUTION),
            .INDEX_W    (INDEX_W)
        ) u_lane (
            .en      (lane_en[l]),
            .x       (lane_x[l]),
            .i       (lane_i[l]),
            .max_in  (chain_max[l]),
            .sec_in  (chain_sec[l]),
            .idx_in  (chain_idx[l]),
            .max_out (chain_max[l+1]),
            .sec_out (chain_sec[l+1]),
            .idx_out (chain_idx[l+1])
        );
    end

    // max >= second always holds, so the widened difference is non-negative.
    assign margin_next = {chain_max[LANES][RESOLUTION-1], chain_max[LANES]}
                       - {chain_sec[LANES][RESOLUTION-1], chain_sec[LANES]};

    // Control FSM, running result and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            beat            <= '0;
            run_max         <= MIN_ACT;
            run_sec         <= MIN_ACT;
            run_idx         <= '0;
            out_valid       <= 1'b0;
            predicted_digit <= '0;
            max_activation  <= '0;
            runner_up       <= '0;
            margin          <= '0;
`ifdef ARGMAX_CONFIDENCE_EN
            low_confidence  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SCAN;
                        beat    <= '0;
                        run_max <= MIN_ACT;
                        run_sec <= MIN_ACT;
                        run_idx <= '0;
                    end
                end
                SCAN: begin
                    run_max <= chain_max[LANES];
                    run_sec <= chain_sec[LANES];
                    run_idx <= chain_idx[LANES];
                    if (last_beat) begin
                        state           <= DONE;
                        out_valid       <= 1'b1;
                        predicted_digit <= chain_idx[LANES];
                        max_activation  <= chain_max[LANES];
                        runner_up       <= chain_sec[LANES];
                        margin          <= margin_next;
`ifdef ARGMAX_CONFIDENCE_EN
                        low_confidence  <= (int'(margin_next) < CONF_THRESHOLD);
`endif
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_stream_unit.sv
// tb_argmax_stream_unit: directed bench for argmax_stream_unit using three
// instances (N=10/LANES=1, N=10/LANES=4, N=1).
module tb_argmax_stream_unit;

    typedef int vec10_t [10];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // instance a: N=10, LANES=1
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [79:0] a_act = '0;
    logic [3:0]  a_digit;
    logic [7:0]  a_max, a_ru;
    logic [8:0]  a_margin;
`ifdef ARGMAX_CONFIDENCE_EN
    logic        a_low;
`endif

    // instance b: N=10, LANES=4
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [79:0] b_act = '0;
    logic [3:0]  b_digit;
    logic [7:0]  b_max, b_ru;
    logic [8:0]  b_margin;
`ifdef ARGMAX_CONFIDENCE_EN
    logic        b_low;
`endif

    // instance c: N=1
    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b0;
    logic [7:0]  c_act = '0;
    logic [0:0]  c_digit;
    logic [7:0]  c_max, c_ru;
    logic [8:0]  c_margin;
`ifdef ARGMAX_CONFIDENCE_EN
    logic        c_low;
`endif

    argmax_stream_unit #(.NEURON_NUMBER(10), .RESOLUTION(8), .LANES(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .output_activations(a_act), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .predicted_digit(a_digit), .max_activation(a_max), .runner_up(a_ru),
`ifdef ARGMAX_CONFIDENCE_EN
        .low_confidence(a_low),
`endif
        .margin(a_margin)
    );

    argmax_stream_unit #(.NEURON_NUMBER(10), .RESOLUTION(8), .LANES(4)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .output_activations(b_act), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .predicted_digit(b_digit), .max_activation(b_max), .runner_up(b_ru),
`ifdef ARGMAX_CONFIDENCE_EN
        .low_confidence(b_low),
`endif
        .margin(b_margin)
    );

    argmax_stream_unit #(.NEURON_NUMBER(1), .RESOLUTION(8), .LANES(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .output_activations(c_act), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .predicted_digit(c_digit), .max_activation(c_max), .runner_up(c_ru),
`ifdef ARGMAX_CONFIDENCE_EN
        .low_confidence(c_low),
`endif
        .margin(c_margin)
    );

    function automatic logic [79:0] mk10(input vec10_t e);
        logic [79:0] r;
        for (int i = 0; i < 10; i++) r[i*8 +: 8] = 8'(e[i]);
        return r;
    endfunction

    // Present a vector for one edge; returns at the negedge after acceptance.
    task automatic accept_a(input logic [79:0] v);
        @(negedge clk); a_act = v; a_in_valid = 1'b1;
        @(negedge clk); a_in_valid = 1'b0;
    endtask

    task automatic accept_b(input logic [79:0] v);
        @(negedge clk); b_act = v; b_in_valid = 1'b1;
        @(negedge clk); b_in_valid = 1'b0;
    endtask

    // Count negedges until out_valid, bounded at 50.
    task automatic wait_a(output int cyc);
        cyc = 0;
        while (!a_out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    endtask

    task automatic wait_b(output int cyc);
        cyc = 0;
        while (!b_out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    endtask

    task automatic release_a();
        a_out_ready = 1'b1; @(negedge clk); a_out_ready = 1'b0;
    endtask

    task automatic release_b();
        b_out_ready = 1'b1; @(negedge clk); b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_high got %0b want 0", a_in_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b want 1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", a_out_valid); end
        checks++; if ({a_digit, a_max, a_ru, a_margin} !== 29'd0) begin errors++; $display("FAIL rst_outputs got %0d/%0d/%0d/%0d want 0", a_digit, a_max, a_ru, a_margin); end
        checks++; if (b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_bc got %0b%0b want 11", b_in_ready, c_in_ready); end
    endtask

    task automatic test_basic();
        int cyc;
        accept_a(mk10('{5, -3, 100, 7, 99, 0, 0, 0, 0, 0}));
        a_act = '1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_scan got %0b want 0", a_in_ready); end
        wait_a(cyc);
        checks++; if (cyc != 10) begin errors++; $display("FAIL basic_latency got %0d want 10", cyc); end
        checks++; if (a_digit !== 4'd2) begin errors++; $display("FAIL basic_digit got %0d want 2", a_digit); end
        checks++; if (a_max !== 8'd100) begin errors++; $display("FAIL basic_max got %0d want 100", $signed(a_max)); end
        checks++; if (a_ru !== 8'd99) begin errors++; $display("FAIL basic_runner_up got %0d want 99", $signed(a_ru)); end
        checks++; if (a_margin !== 9'd1) begin errors++; $display("FAIL basic_margin got %0d want 1", a_margin); end
        release_a();
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL basic_release got v=%0b r=%0b want v=0 r=1", a_out_valid, a_in_ready); end
    endtask

    task automatic test_tie();
        int cyc;
        accept_a(mk10('{-1, -1, -1, 42, -1, -1, -1, -1, 42, -1}));
        wait_a(cyc);
        checks++; if (a_digit !== 4'd8) begin errors++; $display("FAIL tie_digit got %0d want 8", a_digit); end
        checks++; if (a_max !== 8'd42 || a_ru !== 8'd42) begin errors++; $display("FAIL tie_values got %0d/%0d want 42/42", $signed(a_max), $signed(a_ru)); end
        checks++; if (a_margin !== 9'd0) begin errors++; $display("FAIL tie_margin got %0d want 0", a_margin); end
        release_a();
    endtask

    task automatic test_extremes();
        int cyc;
        accept_a(mk10('{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128}));
        wait_a(cyc);
        checks++; if (a_digit !== 4'd9) begin errors++; $display("FAIL allmin_digit got %0d want 9", a_digit); end
        checks++; if (a_max !== 8'h80 || a_ru !== 8'h80) begin errors++; $display("FAIL allmin_values got %0d/%0d want -128/-128", $signed(a_max), $signed(a_ru)); end
        checks++; if (a_margin !== 9'd0) begin errors++; $display("FAIL allmin_margin got %0d want 0", a_margin); end
        release_a();
        accept_a(mk10('{-128, 127, 127, 127, 127, 127, 127, 127, 127, 127}));
        wait_a(cyc);
        checks++; if (a_digit !== 4'd9) begin errors++; $display("FAIL allmax_digit got %0d want 9", a_digit); end
        checks++; if (a_max !== 8'd127 || a_ru !== 8'd127) begin errors++; $display("FAIL allmax_values got %0d/%0d want 127/127", $signed(a_max), $signed(a_ru)); end
        checks++; if (a_margin !== 9'd0) begin errors++; $display("FAIL allmax_margin got %0d want 0", a_margin); end
        release_a();
    endtask

    task automatic test_lanes4_hold();
        int cyc;
        accept_b(mk10('{10, 10, 10, 10, 10, 10, 10, 10, 10, 50}));
        wait_b(cyc);
        checks++; if (cyc != 3) begin errors++; $display("FAIL lanes4_latency got %0d want 3", cyc); end
        checks++; if (b_digit !== 4'd9) begin errors++; $display("FAIL lanes4_digit got %0d want 9", b_digit); end
        checks++; if (b_max !== 8'd50 || b_ru !== 8'd10) begin errors++; $display("FAIL lanes4_values got %0d/%0d want 50/10", $signed(b_max), $signed(b_ru)); end
        checks++; if (b_margin !== 9'd40) begin errors++; $display("FAIL lanes4_margin got %0d want 40", b_margin); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0 || b_digit !== 4'd9 || b_max !== 8'd50 || b_ru !== 8'd10 || b_margin !== 9'd40) begin
                errors++;
                $display("FAIL lanes4_hold cycle %0d got v=%0b r=%0b d=%0d m=%0d want v=1 r=0 d=9 m=40", i, b_out_valid, b_in_ready, b_digit, b_margin);
            end
        end
        release_b();
        checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL lanes4_release got v=%0b r=%0b want v=0 r=1", b_out_valid, b_in_ready); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        accept_b(mk10('{-5, 20, 3, 20, -7, 21, 19, 1, 2, 0}));
        wait_b(cyc);
        checks++; if (cyc != 3) begin errors++; $display("FAIL b2b_latency got %0d want 3", cyc); end
        checks++; if (b_digit !== 4'd5 || b_max !== 8'd21 || b_ru !== 8'd20 || b_margin !== 9'd1) begin
            errors++; $display("FAIL b2b_result got d=%0d max=%0d ru=%0d m=%0d want d=5 max=21 ru=20 m=1", b_digit, $signed(b_max), $signed(b_ru), b_margin);
        end
        release_b();
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        bit seen;
        accept_a(mk10('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin errors++; $display("FAIL midrst_during got v=%0b r=%0b want v=0 r=0", a_out_valid, a_in_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1 || a_digit !== 4'd0 || a_margin !== 9'd0) begin errors++; $display("FAIL midrst_after got r=%0b d=%0d m=%0d want r=1 d=0 m=0", a_in_ready, a_digit, a_margin); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); if (a_out_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_result got %0b want 0", seen); end
        accept_a(mk10('{0, 0, 0, 0, 0, 0, 33, 0, -4, 12}));
        wait_a(cyc);
        checks++; if (cyc != 10 || a_digit !== 4'd6 || a_max !== 8'd33 || a_ru !== 8'd12 || a_margin !== 9'd21) begin
            errors++; $display("FAIL midrst_fresh got lat=%0d d=%0d max=%0d ru=%0d m=%0d want lat=10 d=6 max=33 ru=12 m=21", cyc, a_digit, $signed(a_max), $signed(a_ru), a_margin);
        end
        release_a();
    endtask

    task automatic test_single_neuron();
        int cyc;
        @(negedge clk); c_act = 8'(-100); c_in_valid = 1'b1;
        @(negedge clk); c_in_valid = 1'b0;
        cyc = 0;
        while (!c_out_valid && cyc < 50) begin @(negedge clk); cyc++; end
        checks++; if (cyc != 1) begin errors++; $display("FAIL n1_latency got %0d want 1", cyc); end
        checks++; if (c_digit !== 1'b0 || c_max !== 8'(-100) || c_ru !== 8'h80) begin errors++; $display("FAIL n1_values got d=%0d max=%0d ru=%0d want d=0 max=-100 ru=-128", c_digit, $signed(c_max), $signed(c_ru)); end
        checks++; if (c_margin !== 9'd28) begin errors++; $display("FAIL n1_margin got %0d want 28", c_margin); end
        c_out_ready = 1'b1; @(negedge clk); c_out_ready = 1'b0;
    endtask

`ifdef ARGMAX_CONFIDENCE_EN
    task automatic test_confidence();
        int cyc;
        accept_a(mk10('{60, 50, 0, 0, 0, 0, 0, 0, 0, 0}));
        wait_a(cyc);
        checks++; if (a_margin !== 9'd10 || a_low !== 1'b1) begin errors++; $display("FAIL conf_low got m=%0d low=%0b want m=10 low=1", a_margin, a_low); end
        release_a();
        accept_a(mk10('{40, 0, 0, 0, 0, 0, 0, 0, 0, 60}));
        wait_a(cyc);
        checks++; if (a_margin !== 9'd20 || a_low !== 1'b0) begin errors++; $display("FAIL conf_high got m=%0d low=%0b want m=20 low=0", a_margin, a_low); end
        release_a();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_extremes();
        test_lanes4_hold();
        test_back_to_back();
        test_reset_mid_scan();
        test_single_neuron();
`ifdef ARGMAX_CONFIDENCE_EN
        test_confidence();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/argmax_stream_unit.md
Name: argmax_stream_unit

Overview:
- Sequential successor to the combinational output-layer argmax of the digit-recognition network.
- Accepts one packed vector of signed output-layer activations per transaction through a valid/ready handshake. Scans it LANES elements per cycle.
- Returns the winning neuron index, the max value, the runner-up value and the decision margin through a second valid/ready handshake.
- Sits between the output layer and the display/UART result path.

Parameters:
- NEURON_NUMBER, 10, number of activations per vector (≥1)
- RESOLUTION, 8, bit width of each signed two's-complement activation
- LANES, 1, elements compared per scan cycle (1..NEURON_NUMBER; need not divide NEURON_NUMBER)
- INDEX_W, $clog2(NEURON_NUMBER) min 1, width of the index output (derived, not overridden)

Ports:
- clk  in  1  single system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  activation vector valid
- in_ready  out  1  unit can accept a vector
- output_activations  in  RESOLUTION*NEURON_NUMBER  packed signed activations, neuron i at [i*RESOLUTION +: RESOLUTION]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- predicted_digit  out  INDEX_W  index of max activation
- max_activation  out  RESOLUTION  signed max value
- runner_up  out  RESOLUTION  signed second-ranked value
- margin  out  RESOLUTION+1  unsigned max_activation − runner_up

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; out_valid 0; predicted_digit, max_activation, runner_up and margin all 0; in_ready 0 while rst is high, then 1.
- States and transitions:
  - IDLE → SCAN on in_valid && in_ready. The vector is captured into an internal register, and the running max, second and index are initialised to MIN_ACT (−2^(RESOLUTION−1)), MIN_ACT and 0. The beat counter is cleared.
  - SCAN: each cycle processes beat b, covering elements b*LANES .. min(b*LANES+LANES, N)−1. Lanes are chained combinationally in ascending index order. After the last beat (B = ceil(N/LANES)), go to DONE and register the outputs.
  - DONE: out_valid is 1. Go to IDLE on out_ready. Outputs hold stable while out_valid && !out_ready.
- in_ready is 1 only in IDLE (and rst low). No new vector is accepted in SCAN or DONE.
- Latency: out_valid rises B edges after the accepting edge (N=10, LANES=1 → 10; LANES=4 → 3). Minimum initiation interval is B+2 cycles.
- Update rule per element x at index i:
  - If x ≥ max: second ← max, max ← x, idx ← i. Ties therefore go to the later index, and margin becomes 0.
  - Else if x ≥ second: second ← x.
- All compares are signed RESOLUTION-bit. margin is computed at RESOLUTION+1 bits; no overflow, range 0..2^RESOLUTION−1.
- N=1: runner_up = MIN_ACT, and margin = max − MIN_ACT.
- Input vector changes after acceptance are ignored, because the captured copy is used.
- rst asserted mid-SCAN or in DONE: on the next edge, return to the reset state. The partial result is discarded and out_valid goes 0.
- out_ready high in IDLE or SCAN has no effect.

Optional Feature:
- Macro: ARGMAX_CONFIDENCE_EN.
- When defined:
  - Adds parameter CONF_THRESHOLD (default 16).
  - Adds output low_confidence (1 bit), registered with the other outputs: 1 when margin < CONF_THRESHOLD.
  - low_confidence resets to 0 and is held stable under the same rules as the other outputs.
- When undefined: neither the port nor the parameter exists, and the logic is identical otherwise.

Decomposition:
- Package argmax_pkg holds:
  - state encoding IDLE/SCAN/DONE;
  - a clog2-based index-width function with minimum 1;
  - a beat-count function ceil(N/LANES);
  - a MIN_ACT(RESOLUTION) constant function.
- Sub-module argmax_lane_cmp: combinational single-element update of (max, second, idx) given (x, i). It is instantiated LANES times in a chain. The top level holds the FSM, the capture register, the beat counter and the output registers.

Test Plan:
- N=10, R=8, LANES=1; vector {0:5, 1:-3, 2:100, 3:7, 4:99, rest:0} → after 10 cycles: digit=2, max=100, runner_up=99, margin=1.
- Tie: neurons 3 and 8 both 42, others −1 → digit=8, runner_up=42, margin=0.
- All −128 → digit=9, max=−128, runner_up=−128, margin=0. All 127 with neuron 0 at −128 → digit=9, margin=0.
- LANES=4, N=10 (partial last beat), neuron 9 = 50, others 10 → out_valid 3 cycles after accept, digit=9, margin=40. Also hold out_ready=0 for 5 cycles: outputs stable, in_ready=0, then out_ready=1 → IDLE next cycle.
- Reset pulse during SCAN beat 4 → out_valid stays 0, in_ready=1 after reset. A fresh vector then completes correctly.
- ARGMAX_CONFIDENCE_EN, CONF_THRESHOLD=16: max 60 vs 50 → low_confidence=1. Max 60 vs 40 → 0. Also N=1, value −100 → margin=28.
